mem_writer: RTL and testbench
=============================

MEM_WRITER -- requirements
Module: mem_writer

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 8, data/register byte width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, memory address width.
REQ-003 SHALL have port phi1  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request pulse, sampled only when not busy.
REQ-006 SHALL have port op_kind  input  3  STORE=0, PUSH1=1, JSR=2, BRK=3, IRQ=4; 5-7 invalid.
REQ-007 SHALL have port addr_in  input  ADDR_WIDTH  target address for STORE.
REQ-008 SHALL have port data_in  input  REG_WIDTH  byte for STORE/PUSH1.
REQ-009 SHALL have port pc_in  input  ADDR_WIDTH  PC value pushed by JSR/BRK/IRQ.
REQ-010 SHALL have port status_in  input  REG_WIDTH  P register pushed by BRK/IRQ.
REQ-011 SHALL have port sp_in  input  REG_WIDTH  current stack pointer.
REQ-012 SHALL have port addr_out  output  ADDR_WIDTH  write address.
REQ-013 SHALL have port data_out  output  REG_WIDTH  write data.
REQ-014 SHALL have port write_en  output  1  memory write strobe, one byte per cycle.
REQ-015 SHALL have port sp_next  output  REG_WIDTH  updated stack pointer.
REQ-016 SHALL have port sp_load  output  1  one-cycle strobe to load sp_next into SP.
REQ-017 SHALL have ports busy and done  output  1 each  operation in progress / one-cycle completion pulse.

Function
REQ-018 SHALL implement states IDLE, WRITE, DONE; byte counter 0-2 tracks position within WRITE.
REQ-019 SHALL, on start=1 in IDLE or DONE, latch op_kind, addr_in, data_in, pc_in, status_in, sp_in and enter WRITE (valid op) or DONE (invalid op).
REQ-020 SHALL ignore start while in WRITE; latched inputs SHALL NOT change mid-operation.
REQ-021 SHALL write byte counts: STORE 1, PUSH1 1, JSR 2, BRK 3, IRQ 3.
REQ-022 SHALL write in this order: JSR PCH,PCL; BRK/IRQ PCH,PCL,P.
REQ-023 SHALL assert write_en=1, busy=1 for exactly one cycle per byte, consecutive cycles, first write the cycle after start is sampled.
REQ-024 SHALL use addr_out=addr_in for STORE; for stack ops addr_out = STACK_BASE + sp, where sp starts at latched sp_in and decrements by 1 after each byte.
REQ-025 SHALL compute sp mod 2^REG_WIDTH: 0x00 decrements to 0xFF, and the address stays within 0x0100-0x01FF.
REQ-026 SHALL push P as status|0x30 for BRK and (status&0xEF)|0x20 for IRQ.
REQ-027 SHALL, in DONE, pulse done=1 for one cycle with write_en=0, busy=0; for stack ops also sp_load=1 with sp_next = sp_in minus byte count.
REQ-028 SHALL keep sp_load=0 for STORE and invalid ops; invalid op SHALL produce done with no write.
REQ-029 SHALL return from DONE to IDLE unless start=1 (back-to-back accepted, no idle gap).
REQ-030 SHALL hold addr_out/data_out stable at last value whenever write_en=0.

Reset
REQ-031 SHALL, when reset=1 at a phi1 edge, enter IDLE and clear counter, write_en, sp_load, busy, done, addr_out, data_out, sp_next to 0, overriding start.
REQ-032 SHALL abort any operation on reset mid-WRITE: no further writes, no sp_load, no done.

Structure
REQ-033 SHALL take STACK_BASE (0x0100), op_kind encodings, and status bit positions (B=4, unused=5) from the shared defines package.
REQ-034 SHALL be a single module; no sub-module is natural.

Verification
REQ-035 STORE addr_in=0x0234, data_in=0x5A -> one write 0x0234<=0x5A next cycle, done cycle after, sp_load=0.
REQ-036 JSR sp_in=0xFD, pc_in=0x8012 -> 0x01FD<=0x80, 0x01FC<=0x12, done with sp_load=1, sp_next=0xFB.
REQ-037 BRK sp_in=0x01, pc_in=0xC003, status=0x81 -> 0x0101<=0xC0, 0x0100<=0x03, 0x01FF<=0xB1, sp_next=0xFE.
REQ-038 IRQ status=0xB1, sp_in=0xFF -> third write 0x01FD<=0xA1; start pulsed mid-write ignored.
REQ-039 PUSH1 started, reset=1 in its write cycle -> next cycle all outputs 0, no done, no sp_load.
REQ-040 op_kind=6 -> no write_en, done pulse next cycle; start in DONE with PUSH1 -> write follows immediately.

Source files
------------

// File: rtl/mem_writer_pkg.sv
// mem_writer_pkg: shared stack/opcode/status defines for the memory writer
package mem_writer_pkg;
  localparam logic [15:0] STACK_BASE = 16'h0100;
  localparam int B_BIT = 4;
  localparam int U_BIT = 5;
  typedef enum logic [2:0] {
    OP_STORE = 3'd0,
    OP_PUSH1 = 3'd1,
    OP_JSR   = 3'd2,
    OP_BRK   = 3'd3,
    OP_IRQ   = 3'd4
  } op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_DONE} state_e;
  function automatic logic [1:0] byte_count(input logic [2:0] op);
    return op == OP_JSR ? 2'd2 :
           (op == OP_BRK || op == OP_IRQ) ? 2'd3 :
           (op == OP_STORE || op == OP_PUSH1) ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/mem_writer.sv
// mem_writer: sequences STORE/PUSH1/JSR/BRK/IRQ memory writes one byte per cycle
module mem_writer
  import mem_writer_pkg::*;
#(
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  phi1,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            op_kind,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [REG_WIDTH-1:0]  data_in,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic [REG_WIDTH-1:0]  status_in,
  input  logic [REG_WIDTH-1:0]  sp_in,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic [REG_WIDTH-1:0]  data_out,
  output logic                  write_en,
  output logic [REG_WIDTH-1:0]  sp_next,
  output logic                  sp_load,
  output logic                  busy,
  output logic                  done
);
  localparam logic [REG_WIDTH-1:0] B_MASK = REG_WIDTH'(1) << B_BIT;
  localparam logic [REG_WIDTH-1:0] U_MASK = REG_WIDTH'(1) << U_BIT;
  state_e                  state;
  logic [1:0]              cnt, idx, n;
  logic [2:0]              op_q, op_s;
  logic [ADDR_WIDTH-1:0]   addr_q, pc_q, addr_s, pc_s, byte_addr;
  logic [REG_WIDTH-1:0]    data_q, status_q, sp_q, data_s, status_s, sp_s, sp_k, p_val, byte_data;
  logic                    accept, is_stack;
  // The first byte is built from the live inputs on the accepting edge, later bytes from the latched copy.
  always_comb begin
    accept    = start && state != ST_WRITE;
    op_s      = accept ? op_kind : op_q;
    addr_s    = accept ? addr_in : addr_q;
    data_s    = accept ? data_in : data_q;
    pc_s      = accept ? pc_in : pc_q;
    status_s  = accept ? status_in : status_q;
    sp_s      = accept ? sp_in : sp_q;
    idx       = accept ? 2'd0 : cnt + 2'd1;
    n         = byte_count(op_s);
    is_stack  = op_s inside {OP_PUSH1, OP_JSR, OP_BRK, OP_IRQ};
    sp_k      = sp_s - REG_WIDTH'(idx);
    p_val     = op_s == OP_BRK ? status_s | B_MASK | U_MASK : (status_s & ~B_MASK) | U_MASK;
    byte_addr = op_s == OP_STORE ? addr_s : ADDR_WIDTH'(STACK_BASE) + ADDR_WIDTH'(sp_k);
    byte_data = (op_s == OP_STORE || op_s == OP_PUSH1) ? data_s :
                idx == 2'd0 ? REG_WIDTH'(pc_s >> REG_WIDTH) :
                idx == 2'd1 ? pc_s[REG_WIDTH-1:0] : p_val;
  end
  always_ff @(posedge phi1) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      write_en <= 1'b0;
      sp_load  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      addr_out <= '0;
      data_out <= '0;
      sp_next  <= '0;
    end else begin
      done    <= 1'b0;
      sp_load <= 1'b0;
      if (accept) begin
        op_q     <= op_kind;
        addr_q   <= addr_in;
        data_q   <= data_in;
        pc_q     <= pc_in;
        status_q <= status_in;
        sp_q     <= sp_in;
      end
      if (accept || state == ST_WRITE) begin
        if (idx < n) begin
          state    <= ST_WRITE;
          cnt      <= idx;
          write_en <= 1'b1;
          busy     <= 1'b1;
          addr_out <= byte_addr;
          data_out <= byte_data;
        end else begin
          state    <= ST_DONE;
          write_en <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b1;
          sp_load  <= is_stack;
          if (is_stack) sp_next <= sp_s - REG_WIDTH'(n);
        end
      end else begin
        state <= ST_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_mem_writer.sv
// tb_mem_writer: directed self-checking bench for mem_writer
module tb_mem_writer;
  logic        phi1 = 1'b0;
  logic        reset, start;
  logic [2:0]  op_kind;
  logic [15:0] addr_in, pc_in, addr_out;
  logic [7:0]  data_in, status_in, sp_in, data_out, sp_next;
  logic        write_en, sp_load, busy, done;
  int          n_cmp = 0;
  int          n_err = 0;
  mem_writer dut (
    .phi1(phi1), .reset(reset), .start(start), .op_kind(op_kind),
    .addr_in(addr_in), .data_in(data_in), .pc_in(pc_in), .status_in(status_in), .sp_in(sp_in),
    .addr_out(addr_out), .data_out(data_out), .write_en(write_en),
    .sp_next(sp_next), .sp_load(sp_load), .busy(busy), .done(done)
  );
  always #5 phi1 = ~phi1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(negedge phi1);
  endtask
  task automatic wr(input string tag, input logic [15:0] a, input logic [7:0] d);
    chk({tag, " write_en"}, 32'(write_en), 32'd1);
    chk({tag, " busy"}, 32'(busy), 32'd1);
    chk({tag, " addr"}, 32'(addr_out), 32'(a));
    chk({tag, " data"}, 32'(data_out), 32'(d));
  endtask
  task automatic fin(input string tag, input logic sl, input logic [7:0] spn);
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " write_en"}, 32'(write_en), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " sp_load"}, 32'(sp_load), 32'(sl));
    if (sl) chk({tag, " sp_next"}, 32'(sp_next), 32'(spn));
  endtask
  task automatic go(input logic [2:0] op);
    start = 1'b1;
    op_kind = op;
    step();
    start = 1'b0;
  endtask
  initial begin
    reset = 1'b1; start = 1'b0; op_kind = 3'd0;
    addr_in = '0; data_in = '0; pc_in = '0; status_in = '0; sp_in = '0;
    step(); step();
    chk("rst write_en", 32'(write_en), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst sp_load", 32'(sp_load), 32'd0);
    chk("rst addr", 32'(addr_out), 32'd0);
    chk("rst data", 32'(data_out), 32'd0);
    chk("rst sp_next", 32'(sp_next), 32'd0);
    reset = 1'b0;
    step();
    addr_in = 16'h0234; data_in = 8'h5A;
    go(3'd0);
    wr("store", 16'h0234, 8'h5A);
    step();
    fin("store", 1'b0, 8'h00);
    chk("store hold addr", 32'(addr_out), 32'h0234);
    step();
    chk("store idle done", 32'(done), 32'd0);
    sp_in = 8'hFD; pc_in = 16'h8012;
    go(3'd2);
    wr("jsr b0", 16'h01FD, 8'h80);
    step();
    wr("jsr b1", 16'h01FC, 8'h12);
    step();
    fin("jsr", 1'b1, 8'hFB);
    step();
    sp_in = 8'h01; pc_in = 16'hC003; status_in = 8'h81;
    go(3'd3);
    wr("brk b0", 16'h0101, 8'hC0);
    step();
    wr("brk b1", 16'h0100, 8'h03);
    step();
    wr("brk b2", 16'h01FF, 8'hB1);
    step();
    fin("brk", 1'b1, 8'hFE);
    step();
    sp_in = 8'hFF; pc_in = 16'h1234; status_in = 8'hB1;
    go(3'd4);
    wr("irq b0", 16'h01FF, 8'h12);
    start = 1'b1; op_kind = 3'd0; addr_in = 16'h0000; data_in = 8'h00; sp_in = 8'h00;
    step();
    start = 1'b0;
    wr("irq b1", 16'h01FE, 8'h34);
    step();
    wr("irq b2", 16'h01FD, 8'hA1);
    step();
    fin("irq", 1'b1, 8'hFC);
    step();
    chk("irq after write_en", 32'(write_en), 32'd0);
    chk("irq after done", 32'(done), 32'd0);
    sp_in = 8'h10; data_in = 8'h77;
    go(3'd1);
    wr("push1", 16'h0110, 8'h77);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort write_en", 32'(write_en), 32'd0);
    chk("abort addr", 32'(addr_out), 32'd0);
    chk("abort data", 32'(data_out), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    step();
    chk("abort done", 32'(done), 32'd0);
    chk("abort sp_load", 32'(sp_load), 32'd0);
    chk("abort write_en2", 32'(write_en), 32'd0);
    go(3'd6);
    fin("invalid", 1'b0, 8'h00);
    sp_in = 8'h80; data_in = 8'h3C;
    go(3'd1);
    wr("b2b push1", 16'h0180, 8'h3C);
    chk("b2b done", 32'(done), 32'd0);
    step();
    fin("b2b push1", 1'b1, 8'h7F);
    step();
    chk("end done", 32'(done), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
